epp_bram_bridge: RTL and testbench

EPP_BRAM_BRIDGE -- requirements
Module: epp_bram_bridge

---
 rtl/epp_bram_bridge.sv | 146 ++++++++++++++
 tb/tb_epp_bram_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/epp_bram_bridge.sv
// rtl/epp_bram_bridge.sv - EPP host port bridged to a banked 8-bit BRAM through a register map
module epp_bram_bridge #(
    parameter int AW       = 12,
    parameter int BANKS    = 2,
    parameter int AUTO_INC = 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 stbAddrN,
    input  logic                 stbDataN,
    input  logic                 ctrlWrN,
    input  logic [7:0]           busEppIn,
    output logic [7:0]           busEppOut,
    output logic                 eppWait,
    output logic [AW-1:0]        busBramAddr,
    output logic [7:0]           busBramOut,
    input  logic [8*BANKS-1:0]   busBramIn,
    output logic [BANKS-1:0]     ctrlWeBram,
    input  logic                 stmBusy
);

    typedef enum logic [2:0] {
        S_IDLE, S_AWR, S_ARD, S_DWR, S_DRD1, S_DRD2, S_HOLD, S_ACK
    } state_t;

    localparam logic [3:0] BANKS4 = 4'(BANKS);

    state_t      state, state_nxt;
    logic [1:0]  addr_sync, data_sync, wr_sync;
    logic [1:0]  settle;
    logic        armed;
    logic        acc_addr;
    logic [7:0]  epp_addr;
    logic [AW-1:0] ptr;
    logic [2:0]  bank;
    logic        wrap_flag;

    logic        addr_s, data_s, wr_s, is_data, inc_ptr, strobe_hi;
    logic [7:0]  reg_rdata, ptr_hi, bram_rd;
    logic [2:0]  bank_wr;

    assign addr_s    = addr_sync[1];
    assign data_s    = data_sync[1];
    assign wr_s      = wr_sync[1];
    assign is_data   = (epp_addr == 8'h03);
    assign strobe_hi = acc_addr ? addr_s : data_s;
    assign inc_ptr   = (AUTO_INC != 0) && (((state == S_DWR) && is_data) || (state == S_DRD2));
    assign bank_wr   = ({1'b0, busEppIn[2:0]} >= BANKS4) ? 3'(BANKS - 1) : busEppIn[2:0];

    always_comb begin
        ptr_hi = '0;
        ptr_hi[AW-9:0] = ptr[AW-1:8];
        case (epp_addr)
            8'h00:   reg_rdata = ptr[7:0];
            8'h01:   reg_rdata = ptr_hi;
            8'h02:   reg_rdata = {5'b0, bank};
            8'h04:   reg_rdata = {6'b0, wrap_flag, stmBusy};
            default: reg_rdata = 8'h00;
        endcase
    end

    always_comb begin
        bram_rd    = 8'h00;
        ctrlWeBram = '0;
        for (int k = 0; k < BANKS; k++) begin
            if (bank == 3'(k)) begin
                bram_rd       = busBramIn[8*k +: 8];
                ctrlWeBram[k] = (state == S_DWR) && is_data;
            end
        end
    end

    assign busBramAddr = ptr;
    assign busBramOut  = (state == S_DWR) ? busEppIn : 8'h00;
    assign eppWait     = (state == S_ACK);

    // A strobe already low when reset releases is not acted on until it has been seen high.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (armed && !addr_s)
                    state_nxt = wr_s ? S_ARD : S_AWR;
                else if (armed && !data_s)
                    state_nxt = (is_data && stmBusy) ? S_HOLD : (wr_s ? S_DRD1 : S_DWR);
            end
            S_AWR, S_ARD, S_DWR, S_DRD2: state_nxt = S_ACK;
            S_DRD1: state_nxt = is_data ? S_DRD2 : S_ACK;
            S_HOLD: if (!stmBusy) state_nxt = wr_s ? S_DRD1 : S_DWR;
            S_ACK:  if (strobe_hi) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= S_IDLE;
            addr_sync <= 2'b11;
            data_sync <= 2'b11;
            wr_sync   <= 2'b11;
            settle    <= 2'b00;
            armed     <= 1'b0;
            acc_addr  <= 1'b0;
            epp_addr  <= 8'h00;
            ptr       <= '0;
            bank      <= 3'd0;
            wrap_flag <= 1'b0;
            busEppOut <= 8'h00;
        end else begin
            addr_sync <= {addr_sync[0], stbAddrN};
            data_sync <= {data_sync[0], stbDataN};
            wr_sync   <= {wr_sync[0], ctrlWrN};
            settle    <= {settle[0], 1'b1};
            if (settle[1] && addr_s && data_s)
                armed <= 1'b1;
            state <= state_nxt;
            if (state == S_IDLE && state_nxt != S_IDLE)
                acc_addr <= (state_nxt == S_AWR) || (state_nxt == S_ARD);
            case (state)
                S_AWR: epp_addr  <= busEppIn;
                S_ARD: busEppOut <= epp_addr;
                S_DWR: begin
                    case (epp_addr)
                        8'h00:   ptr[7:0]    <= busEppIn;
                        8'h01:   ptr[AW-1:8] <= busEppIn[AW-9:0];
                        8'h02:   bank        <= bank_wr;
                        8'h04:   if (busEppIn[1]) wrap_flag <= 1'b0;
                        default: ;
                    endcase
                end
                S_DRD1: if (!is_data) busEppOut <= reg_rdata;
                S_DRD2: busEppOut <= bram_rd;
                default: ;
            endcase
            if (inc_ptr) begin
                if (&ptr) begin
                    ptr       <= '0;
                    wrap_flag <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_epp_bram_bridge.sv
// tb/tb_epp_bram_bridge.sv - directed bench for epp_bram_bridge with a two-bank BRAM model
module tb_epp_bram_bridge;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        stbAddrN = 1'b1;
    logic        stbDataN = 1'b1;
    logic        ctrlWrN = 1'b1;
    logic [7:0]  busEppIn = 8'h00;
    logic [7:0]  busEppOut;
    logic        eppWait;
    logic [11:0] busBramAddr;
    logic [7:0]  busBramOut;
    logic [15:0] busBramIn = 16'h0000;
    logic [1:0]  ctrlWeBram;
    logic        stmBusy = 1'b0;

    int checks = 0;
    int failures = 0;
    int we_cnt0 = 0;
    int we_cnt1 = 0;
    logic [11:0] last_we_addr = '0;
    logic [7:0]  last_we_data = '0;
    logic [7:0]  mem0 [0:4095];
    logic [7:0]  mem1 [0:4095];

    epp_bram_bridge #(.AW(12), .BANKS(2), .AUTO_INC(1)) dut (
        .clk(clk), .rstN(rstN), .stbAddrN(stbAddrN), .stbDataN(stbDataN),
        .ctrlWrN(ctrlWrN), .busEppIn(busEppIn), .busEppOut(busEppOut),
        .eppWait(eppWait), .busBramAddr(busBramAddr), .busBramOut(busBramOut),
        .busBramIn(busBramIn), .ctrlWeBram(ctrlWeBram), .stmBusy(stmBusy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        busBramIn <= {mem1[busBramAddr], mem0[busBramAddr]};
        if (ctrlWeBram[0]) begin
            mem0[busBramAddr] = busBramOut;
            we_cnt0++;
        end
        if (ctrlWeBram[1]) begin
            mem1[busBramAddr] = busBramOut;
            we_cnt1++;
        end
        if (ctrlWeBram != 2'b00) begin
            last_we_addr = busBramAddr;
            last_we_data = busBramOut;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete host cycle; lat/we_at/rel count rising edges after the strobe change.
    task automatic epp_cycle(input bit is_addr, input bit wr, input logic [7:0] din,
                             output logic [7:0] dout, output int lat, output int we_at,
                             output int rel);
        @(negedge clk);
        ctrlWrN  = !wr;
        busEppIn = din;
        if (is_addr) stbAddrN = 1'b0; else stbDataN = 1'b0;
        lat = 0; we_at = 0; rel = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ctrlWeBram != 2'b00 && we_at == 0) we_at = i;
            if (eppWait) begin lat = i; break; end
        end
        dout = busEppOut;
        check("ack_timeout", 32'(lat != 0), 32'd1);
        @(negedge clk);
        stbAddrN = 1'b1;
        stbDataN = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (!eppWait) begin rel = i; break; end
        end
        check("release_timeout", 32'(rel != 0), 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        int lat, we_at, rel, c0, c1;
        bit bad_wait, bad_we;

        repeat (3) @(posedge clk);
        #1;
        check("rst_wait", 32'(eppWait), 32'd0);
        check("rst_we", 32'(ctrlWeBram), 32'd0);
        check("rst_eppout", 32'(busEppOut), 32'h00);
        check("rst_bramout", 32'(busBramOut), 32'h00);
        check("rst_addr", 32'(busBramAddr), 32'h000);
        @(negedge clk) rstN = 1'b1;
        repeat (5) @(negedge clk);

        epp_cycle(1, 1, 8'h00, d, lat, we_at, rel);
        check("awr_lat", 32'(lat), 32'd4);
        epp_cycle(0, 1, 8'h34, d, lat, we_at, rel);
        epp_cycle(1, 1, 8'h01, d, lat, we_at, rel);
        epp_cycle(0, 1, 8'h01, d, lat, we_at, rel);
        check("ptr_0x134", 32'(busBramAddr), 32'h134);
        check("reg_no_we", 32'(we_cnt0 + we_cnt1), 32'd0);

        epp_cycle(1, 0, 8'h00, d, lat, we_at, rel);
        check("ard_data", 32'(d), 32'h01);
        check("ard_lat", 32'(lat), 32'd4);
        epp_cycle(0, 0, 8'h00, d, lat, we_at, rel);
        check("ptr_h_rd", 32'(d), 32'h01);
        epp_cycle(1, 1, 8'h00, d, lat, we_at, rel);
        epp_cycle(0, 0, 8'h00, d, lat, we_at, rel);
        check("ptr_l_rd", 32'(d), 32'h34);

        epp_cycle(1, 1, 8'h03, d, lat, we_at, rel);
        epp_cycle(0, 1, 8'h55, d, lat, we_at, rel);
        check("dwr_lat", 32'(lat), 32'd4);
        check("dwr_we_at", 32'(we_at), 32'd3);
        check("dwr_rel", 32'(rel), 32'd3);
        check("dwr_we_cnt", 32'(we_cnt0), 32'd1);
        check("dwr_we_addr", 32'(last_we_addr), 32'h134);
        check("dwr_we_data", 32'(last_we_data), 32'h55);
        epp_cycle(0, 1, 8'h44, d, lat, we_at, rel);
        check("dwr2_we_cnt", 32'(we_cnt0), 32'd2);
        check("dwr2_we_addr", 32'(last_we_addr), 32'h135);
        check("dwr2_we_data", 32'(last_we_data), 32'h44);
        check("ptr_after_inc", 32'(busBramAddr), 32'h136);

        epp_cycle(1, 1, 8'h02, d, lat, we_at, rel);
        epp_cycle(0, 1, 8'h05, d, lat, we_at, rel);
        epp_cycle(0, 0, 8'h00, d, lat, we_at, rel);
        check("bank_clamp", 32'(d), 32'h01);

        mem1[12'h136] = 8'hA5;
        mem0[12'h136] = 8'h5A;
        epp_cycle(1, 1, 8'h03, d, lat, we_at, rel);
        epp_cycle(0, 0, 8'h00, d, lat, we_at, rel);
        check("drd_bank1", 32'(d), 32'hA5);
        check("drd_lat", 32'(lat), 32'd5);
        check("drd_no_we0", 32'(we_cnt0), 32'd2);
        check("drd_ptr_inc", 32'(busBramAddr), 32'h137);
        epp_cycle(0, 1, 8'h77, d, lat, we_at, rel);
        check("bank1_we_cnt", 32'(we_cnt1), 32'd1);
        check("bank1_we0_cnt", 32'(we_cnt0), 32'd2);
        check("bank1_we_addr", 32'(last_we_addr), 32'h137);

        epp_cycle(1, 1, 8'h00, d, lat, we_at, rel);
        epp_cycle(0, 1, 8'hFF, d, lat, we_at, rel);
        epp_cycle(1, 1, 8'h01, d, lat, we_at, rel);
        epp_cycle(0, 1, 8'h0F, d, lat, we_at, rel);
        check("ptr_0xfff", 32'(busBramAddr), 32'hFFF);
        epp_cycle(1, 1, 8'h03, d, lat, we_at, rel);
        epp_cycle(0, 1, 8'h11, d, lat, we_at, rel);
        check("wrap_ptr", 32'(busBramAddr), 32'h000);
        check("wrap_we_addr", 32'(last_we_addr), 32'hFFF);
        epp_cycle(1, 1, 8'h04, d, lat, we_at, rel);
        epp_cycle(0, 0, 8'h00, d, lat, we_at, rel);
        check("status_wrap", 32'(d), 32'h02);
        epp_cycle(0, 1, 8'h02, d, lat, we_at, rel);
        epp_cycle(0, 0, 8'h00, d, lat, we_at, rel);
        check("status_clr", 32'(d), 32'h00);

        c0 = we_cnt0; c1 = we_cnt1;
        epp_cycle(1, 1, 8'h07, d, lat, we_at, rel);
        epp_cycle(0, 1, 8'h99, d, lat, we_at, rel);
        epp_cycle(0, 0, 8'h00, d, lat, we_at, rel);
        check("unmapped_rd", 32'(d), 32'h00);
        check("unmapped_no_we", 32'(we_cnt0 + we_cnt1), 32'(c0 + c1));

        @(negedge clk) stmBusy = 1'b1;
        epp_cycle(1, 1, 8'h04, d, lat, we_at, rel);
        epp_cycle(0, 0, 8'h00, d, lat, we_at, rel);
        check("status_busy", 32'(d), 32'h01);
        epp_cycle(1, 1, 8'h03, d, lat, we_at, rel);
        check("addr_not_stalled", 32'(lat), 32'd4);
        @(negedge clk);
        ctrlWrN = 1'b0; busEppIn = 8'h66; stbDataN = 1'b0;
        c1 = we_cnt1; bad_wait = 0; bad_we = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (eppWait) bad_wait = 1;
            if (ctrlWeBram != 2'b00) bad_we = 1;
        end
        check("hold_wait_low", 32'(bad_wait), 32'd0);
        check("hold_no_we", 32'(bad_we), 32'd0);
        @(negedge clk) stmBusy = 1'b0;
        @(posedge clk); #1;
        check("hold_we_next", 32'(ctrlWeBram), 32'h2);
        @(posedge clk); #1;
        check("hold_ack", 32'(eppWait), 32'd1);
        check("hold_we_cnt", 32'(we_cnt1), 32'(c1 + 1));
        check("hold_we_data", 32'(last_we_data), 32'h66);
        @(negedge clk) stbDataN = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_released", 32'(eppWait), 32'd0);

        stmBusy = 1'b1;
        ctrlWrN = 1'b0; busEppIn = 8'h33; stbDataN = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_hold_wait", 32'(eppWait), 32'd0);
        @(negedge clk) rstN = 1'b0;
        @(negedge clk) begin rstN = 1'b1; stmBusy = 1'b0; end
        c0 = we_cnt0; c1 = we_cnt1; bad_wait = 0; bad_we = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (eppWait) bad_wait = 1;
            if (ctrlWeBram != 2'b00) bad_we = 1;
        end
        check("rst_abort_wait", 32'(bad_wait), 32'd0);
        check("rst_abort_we", 32'(bad_we), 32'd0);
        check("rst_abort_cnt", 32'(we_cnt0 + we_cnt1), 32'(c0 + c1));
        check("rst_ptr_clear", 32'(busBramAddr), 32'h000);
        @(negedge clk) stbDataN = 1'b1;
        repeat (4) @(negedge clk);
        epp_cycle(0, 1, 8'h22, d, lat, we_at, rel);
        check("rearm_lat", 32'(lat), 32'd4);
        check("rearm_ptr_l", 32'(busBramAddr), 32'h022);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
